key_schedule_seq: RTL and testbench

//  Sequential, parametrised CSA key-schedule generator: takes a 64-bit control word (cw).

---
 rtl/csa_pkg.sv | 18 +
 rtl/key_perm.sv | 29 ++
 rtl/key_schedule_seq.sv | 102 ++++++++++
 tb/tb_key_schedule_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA key-schedule blocks: key width, schedule
// states and the per-round index constant.
package csa_pkg;

  localparam int CSA_KEY_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } ks_state_t;

  // Round index byte replicated across the whole key.
  function automatic logic [CSA_KEY_W-1:0] idx_const(input logic [7:0] i);
    return {8{i}};
  endfunction

endpackage

// File: rtl/key_perm.sv
// CSA key-schedule bit permutation: input bit i moves to output bit DST[i].
// Purely combinational, no state.
module key_perm
  import csa_pkg::*;
(
  input  logic [CSA_KEY_W-1:0] key_in,
  output logic [CSA_KEY_W-1:0] key_out
);

  // Zero-based destination of each input bit.
  localparam logic [5:0] DST [CSA_KEY_W] = '{
    6'd17, 6'd35, 6'd8,  6'd6,  6'd41, 6'd48, 6'd28, 6'd20,
    6'd27, 6'd53, 6'd61, 6'd49, 6'd18, 6'd32, 6'd58, 6'd63,
    6'd23, 6'd19, 6'd36, 6'd38, 6'd1,  6'd52, 6'd26, 6'd0,
    6'd33, 6'd3,  6'd12, 6'd13, 6'd56, 6'd39, 6'd25, 6'd40,
    6'd50, 6'd34, 6'd51, 6'd11, 6'd21, 6'd47, 6'd29, 6'd57,
    6'd44, 6'd30, 6'd7,  6'd24, 6'd22, 6'd46, 6'd60, 6'd16,
    6'd59, 6'd4,  6'd55, 6'd42, 6'd10, 6'd5,  6'd9,  6'd43,
    6'd31, 6'd62, 6'd45, 6'd14, 6'd2,  6'd37, 6'd15, 6'd54
  };

  always_comb begin
    key_out = '0;
    for (int i = 0; i < CSA_KEY_W; i++) begin
      key_out[DST[i]] = key_in[i];
    end
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential CSA key schedule: one key_perm step per accepted stream key,
// keys streamed from index ROUNDS-1 down to 0 and collected into key_all.
module key_schedule_seq
  import csa_pkg::*;
#(
  parameter  int ROUNDS = 7,
  localparam int CNT_W  = $clog2(ROUNDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CSA_KEY_W-1:0]          cw,
  input  logic                          cw_valid,
  output logic                          cw_ready,
  input  logic                          abort,
  output logic [CSA_KEY_W-1:0]          k_data,
  output logic [CNT_W-1:0]              k_idx,
  output logic                          k_valid,
  input  logic                          k_ready,
  output logic [ROUNDS*CSA_KEY_W-1:0]   key_all,
  output logic                          key_all_vld,
  output logic                          busy
);

  ks_state_t              state;
  ks_state_t              state_nxt;
  logic [CSA_KEY_W-1:0]   perm_reg;
  logic [CSA_KEY_W-1:0]   perm_next;
  logic [CNT_W-1:0]       idx;
  logic [CSA_KEY_W-1:0]   key_mem [ROUNDS];
  logic                   accept;
  logic                   hs;

  key_perm u_perm (
    .key_in  (perm_reg),
    .key_out (perm_next)
  );

  assign k_data = perm_reg ^ idx_const(8'(idx));
  assign k_idx  = idx;

  // Abort overrides everything, so it also masks cw_ready and k_valid so
  // that no handshake is reported in a cycle that is being cancelled.
  always_comb begin
    state_nxt = state;
    cw_ready  = 1'b0;
    k_valid   = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE, DONE: begin
        cw_ready = !abort;
        accept   = cw_valid && cw_ready;
        if (accept) state_nxt = GEN;
      end
      GEN: begin
        busy    = 1'b1;
        k_valid = !abort;
        hs      = k_valid && k_ready;
        if (hs && idx == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      perm_reg    <= '0;
      idx         <= '0;
      key_all_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        key_all_vld <= 1'b0;
      end else if (accept) begin
        perm_reg    <= cw;
        idx         <= CNT_W'(ROUNDS - 1);
        key_all_vld <= 1'b0;
      end else if (hs) begin
        perm_reg <= perm_next;
        if (idx == '0) key_all_vld <= 1'b1;
        else           idx         <= idx - CNT_W'(1);
      end
    end
  end

  // Slots are written in place as each key is handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUNDS; i++) key_mem[i] <= '0;
    end else if (hs) begin
      key_mem[idx] <= k_data;
    end
  end

  for (genvar g = 0; g < ROUNDS; g++) begin : g_key_all
    assign key_all[g*CSA_KEY_W +: CSA_KEY_W] = key_mem[g];
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: drives a ROUNDS=7 and a ROUNDS=16 instance with
// the same stimulus and checks both against a transaction-level key model.
module tb_key_schedule_seq;

  localparam int RND [2] = '{7, 16};

  // One-based destination table of the CSA key permutation.
  localparam int DST1 [64] = '{
    18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
    24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
    51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
    60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   cw = '0;
  logic          cwValid = 1'b0;
  logic          abortIn = 1'b0;
  logic          kReady = 1'b0;

  logic          cwReady7, kValid7, keyAllVld7, busy7;
  logic [63:0]   kData7;
  logic [2:0]    kIdx7;
  logic [447:0]  keyAll7;
  logic          cwReady16, kValid16, keyAllVld16, busy16;
  logic [63:0]   kData16;
  logic [3:0]    kIdx16;
  logic [1023:0] keyAll16;

  int testsRun = 0;
  int testsFailed = 0;
  int srcTbl [64];
  int hs7 = 0;

  bit          mGen [2];
  int          mIdx [2];
  bit          mAllVld [2];
  logic [63:0] mKeys [2][256];
  logic [63:0] mAll [2][256];

  key_schedule_seq #(.ROUNDS(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .cw(cw), .cw_valid(cwValid), .cw_ready(cwReady7),
    .abort(abortIn), .k_data(kData7), .k_idx(kIdx7), .k_valid(kValid7),
    .k_ready(kReady), .key_all(keyAll7), .key_all_vld(keyAllVld7), .busy(busy7)
  );

  key_schedule_seq #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .cw(cw), .cw_valid(cwValid), .cw_ready(cwReady16),
    .abort(abortIn), .k_data(kData16), .k_idx(kIdx16), .k_valid(kValid16),
    .k_ready(kReady), .key_all(keyAll16), .key_all_vld(keyAllVld16), .busy(busy16)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] permModel(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[j] = x[srcTbl[j]];
    return y;
  endfunction

  function automatic logic [63:0] idxRep(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i & 255);
  endfunction

  // Key i of an r-round schedule: cw permuted (r-1-i) times, then index-XORed.
  function automatic logic [63:0] roundKey(input logic [63:0] c, input int r, input int i);
    logic [63:0] v;
    v = c;
    for (int n = 0; n < r - 1 - i; n++) v = permModel(v);
    return v ^ idxRep(i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] c);
    cw = c;
    cwValid = 1'b1;
    step(1);
    cwValid = 1'b0;
  endtask

  // Reference behaviour: a schedule is a precomputed list of keys handed out
  // one per accepted transfer, highest index first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mGen[u] <= 1'b0;
        mIdx[u] <= 0;
        mAllVld[u] <= 1'b0;
        for (int i = 0; i < 256; i++) mAll[u][i] <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (abortIn) begin
          mGen[u] <= 1'b0;
          mAllVld[u] <= 1'b0;
        end else if (mGen[u]) begin
          if (kReady) begin
            mAll[u][mIdx[u]] <= mKeys[u][mIdx[u]];
            if (mIdx[u] == 0) begin
              mGen[u] <= 1'b0;
              mAllVld[u] <= 1'b1;
            end else begin
              mIdx[u] <= mIdx[u] - 1;
            end
          end
        end else if (cwValid) begin
          for (int i = 0; i < RND[u]; i++) mKeys[u][i] <= roundKey(cw, RND[u], i);
          mIdx[u] <= RND[u] - 1;
          mGen[u] <= 1'b1;
          mAllVld[u] <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && kValid7 && kReady) hs7 <= hs7 + 1;
  end

  always @(negedge clk) begin
    logic [63:0] aReady, aValid, aBusy, aVld, aData, aIdx, aSlot;
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        if (u == 0) begin
          aReady = 64'(cwReady7); aValid = 64'(kValid7); aBusy = 64'(busy7);
          aVld = 64'(keyAllVld7); aData = kData7; aIdx = 64'(kIdx7);
        end else begin
          aReady = 64'(cwReady16); aValid = 64'(kValid16); aBusy = 64'(busy16);
          aVld = 64'(keyAllVld16); aData = kData16; aIdx = 64'(kIdx16);
        end
        checkOutput($sformatf("cw_ready r%0d", RND[u]), aReady, 64'(!mGen[u] && !abortIn));
        checkOutput($sformatf("k_valid r%0d", RND[u]), aValid, 64'(mGen[u] && !abortIn));
        checkOutput($sformatf("busy r%0d", RND[u]), aBusy, 64'(mGen[u]));
        checkOutput($sformatf("key_all_vld r%0d", RND[u]), aVld, 64'(mAllVld[u]));
        if (mGen[u] && !abortIn) begin
          checkOutput($sformatf("k_data r%0d", RND[u]), aData, mKeys[u][mIdx[u]]);
          checkOutput($sformatf("k_idx r%0d", RND[u]), aIdx, 64'(mIdx[u]));
        end
        if (mAllVld[u]) begin
          for (int i = 0; i < RND[u]; i++) begin
            if (u == 0) aSlot = keyAll7[i*64 +: 64];
            else        aSlot = keyAll16[i*64 +: 64];
            checkOutput($sformatf("key_all r%0d slot %0d", RND[u], i), aSlot, mAll[u][i]);
          end
        end
      end
    end
  end

  initial begin
    int hsStart;
    int lowCnt;
    for (int i = 0; i < 64; i++) srcTbl[DST1[i] - 1] = i;

    // Hand-computed anchors for the model itself.
    checkOutput("model perm bit0", permModel(64'h1), 64'h0000_0000_0002_0000);
    checkOutput("model perm bit15", permModel(64'h8000), 64'h8000_0000_0000_0000);
    checkOutput("model key5 cw1", roundKey(64'h1, 7, 5), 64'h0505_0505_0507_0505);
    checkOutput("model key6 cw0", roundKey(64'h0, 7, 6), 64'h0606_0606_0606_0606);

    #12;
    checkOutput("reset cw_ready", 64'(cwReady7), 64'd1);
    checkOutput("reset k_valid", 64'(kValid7), 64'd0);
    checkOutput("reset busy", 64'(busy7), 64'd0);
    checkOutput("reset key_all_vld", 64'(keyAllVld7), 64'd0);
    checkOutput("reset key_all", 64'(|keyAll7), 64'd0);
    checkOutput("reset cw_ready r16", 64'(cwReady16), 64'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    kReady = 1'b1;

    // cw=0: keys are just the index bytes.
    applyStimulus(64'h0);
    checkOutput("first key data", kData7, 64'h0606_0606_0606_0606);
    checkOutput("first key idx", 64'(kIdx7), 64'd6);
    checkOutput("first key r16", kData16, 64'h0F0F_0F0F_0F0F_0F0F);
    step(6);
    checkOutput("vld before 7 cycles", 64'(keyAllVld7), 64'd0);
    step(1);
    checkOutput("vld at 7 cycles", 64'(keyAllVld7), 64'd1);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("cw0 slot %0d", i), keyAll7[i*64 +: 64], idxRep(i));
    step(12);

    // Stalling downstream: 1,0,0,1 pattern.
    hsStart = hs7;
    applyStimulus(64'h0123_4567_89AB_CDEF);
    for (int c = 0; c < 60; c++) begin
      kReady = (c % 4 == 0) || (c % 4 == 3);
      step(1);
    end
    kReady = 1'b1;
    checkOutput("handshakes r7", 64'(hs7 - hsStart), 64'd7);
    checkOutput("stall done r16", 64'(keyAllVld16), 64'd1);
    step(2);

    // Abort in the third generation cycle.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    step(2);
    abortIn = 1'b1;
    #1;
    checkOutput("abort k_valid", 64'(kValid7), 64'd0);
    step(1);
    abortIn = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy7), 64'd0);
    checkOutput("abort vld", 64'(keyAllVld7), 64'd0);
    checkOutput("abort cw_ready", 64'(cwReady7), 64'd1);
    step(1);
    applyStimulus(64'h0);
    step(18);
    checkOutput("after abort vld", 64'(keyAllVld7), 64'd1);
    checkOutput("after abort slot3", keyAll7[3*64 +: 64], 64'h0303_0303_0303_0303);

    // Back-to-back: second cw waits in DONE.
    cw = 64'hA5A5_0F0F_3C3C_9696;
    cwValid = 1'b1;
    step(1);
    cw = 64'hDEAD_BEEF_CAFE_F00D;
    step(7);
    checkOutput("b2b first vld", 64'(keyAllVld7), 64'd1);
    lowCnt = 0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      if (!keyAllVld7) lowCnt++;
    end
    step(1);
    cwValid = 1'b0;
    checkOutput("b2b low cycles", 64'(lowCnt), 64'd7);
    checkOutput("b2b second vld", 64'(keyAllVld7), 64'd1);
    checkOutput("b2b slot6", keyAll7[6*64 +: 64], 64'hD8AB_B8E9_CCF8_F60B);
    step(20);

    // Random control words.
    for (int n = 0; n < 100; n++) begin
      applyStimulus({$urandom(), $urandom()});
      step(17);
      checkOutput("random done r16", 64'(keyAllVld16), 64'd1);
    end

    // Asynchronous reset in the middle of generation.
    applyStimulus(64'h0123_4567_89AB_CDEF);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async cw_ready", 64'(cwReady7), 64'd1);
    checkOutput("async k_valid", 64'(kValid7), 64'd0);
    checkOutput("async busy", 64'(busy7), 64'd0);
    checkOutput("async vld", 64'(keyAllVld7), 64'd0);
    checkOutput("async k_data", kData7, 64'd0);
    checkOutput("async key_all", 64'(|keyAll7), 64'd0);
    checkOutput("async busy r16", 64'(busy16), 64'd0);
    #3 rst_n = 1'b1;
    step(1);
    checkOutput("release cw_ready", 64'(cwReady7), 64'd1);
    checkOutput("release busy", 64'(busy7), 64'd0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
